// File: rtl/ex_commit.sv
// Commit-side receiver: per-unit 2-entry skid FIFOs, round-robin arbitration,
// one registered register-file write and scoreboard clear per cycle.
module ex_commit #(
  parameter int unsigned NUM_UNITS = 3,
  parameter int unsigned DW        = 64,
  parameter int unsigned RW        = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_UNITS-1:0]    unit_valid,
  input  logic [NUM_UNITS*RW-1:0] unit_rd,
  input  logic [NUM_UNITS*DW-1:0] unit_data,
  output logic [NUM_UNITS-1:0]    unit_stall,
  input  logic                    rf_stall,
  output logic                    rf_we,
  output logic [RW-1:0]           rf_waddr,
  output logic [DW-1:0]           rf_wdata,
  output logic                    sb_clr,
  output logic [RW-1:0]           sb_clr_rn,
  output logic [NUM_UNITS-1:0]    overflow_err
);

  localparam int unsigned EW = RW + DW;
  localparam int unsigned IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0][EW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [NUM_UNITS-1:0][1:0]    occ_q, occ_d;
  logic [NUM_UNITS-1:0]         ovf_q, ovf_d;
  logic [IW-1:0]                last_q, last_d;

  logic                 grant_vld;
  logic [IW-1:0]        grant_idx;
  logic [IW-1:0]        cand;
  logic [NUM_UNITS-1:0] pop;
  logic [EW-1:0]        newe;
  logic [EW-1:0]        head;
  logic [RW-1:0]        head_rd;

  logic          rf_we_q, rf_we_d;
  logic [RW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic          sb_clr_q, sb_clr_d;
  logic [RW-1:0] sb_clr_rn_q, sb_clr_rn_d;

  // Round-robin scan starting one past the last granted unit.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_q;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_UNITS; k++) begin
      cand = IW'((32'(last_q) + k) % NUM_UNITS);
      if (!rf_stall && !grant_vld && (occ_q[cand] != 2'd0)) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    pop = '0;
    if (grant_vld) pop[grant_idx] = 1'b1;
    last_d = grant_vld ? grant_idx : last_q;
  end

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    ovf_d  = ovf_q;
    newe   = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      newe = {unit_rd[i*RW +: RW], unit_data[i*DW +: DW]};
      if (pop[i]) begin
        ent0_d[i] = ent1_q[i];
        occ_d[i]  = occ_q[i] - 2'd1;
      end
      if (unit_valid[i]) begin
        if (pop[i]) begin
          if (occ_q[i] == 2'd1) ent0_d[i] = newe;
          else                  ent1_d[i] = newe;
          occ_d[i] = occ_q[i];
        end else begin
          case (occ_q[i])
            2'd0: begin ent0_d[i] = newe; occ_d[i] = 2'd1; end
            2'd1: begin ent1_d[i] = newe; occ_d[i] = 2'd2; end
            default: ovf_d[i] = 1'b1;
          endcase
        end
      end
    end
  end

  // A granted rd==0 result is consumed without a write.
  always_comb begin
    head        = ent0_q[grant_idx];
    head_rd     = head[EW-1:DW];
    rf_we_d     = grant_vld && (head_rd != '0);
    sb_clr_d    = rf_we_d;
    rf_waddr_d  = rf_we_d ? head_rd : rf_waddr_q;
    rf_wdata_d  = rf_we_d ? head[DW-1:0] : rf_wdata_q;
    sb_clr_rn_d = rf_we_d ? head_rd : sb_clr_rn_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q      <= '0;
      ent1_q      <= '0;
      occ_q       <= '0;
      ovf_q       <= '0;
      last_q      <= IW'(NUM_UNITS - 1);
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      sb_clr_q    <= 1'b0;
      sb_clr_rn_q <= '0;
    end else begin
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      occ_q       <= occ_d;
      ovf_q       <= ovf_d;
      last_q      <= last_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      sb_clr_q    <= sb_clr_d;
      sb_clr_rn_q <= sb_clr_rn_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      unit_stall[i] = (occ_q[i] != 2'd0);
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign sb_clr       = sb_clr_q;
  assign sb_clr_rn    = sb_clr_rn_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_ex_commit.sv
// Bench for ex_commit: directed scenarios plus random traffic, checked against
// a queue-based model of the per-unit buffers and round-robin commit.
module tb_ex_commit;

  localparam int NU = 3;
  localparam int DW = 64;
  localparam int RW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NU-1:0]     unit_valid;
  logic [NU*RW-1:0]  unit_rd;
  logic [NU*DW-1:0]  unit_data;
  logic [NU-1:0]     unit_stall;
  logic              rf_stall;
  logic              rf_we;
  logic [RW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic              sb_clr;
  logic [RW-1:0]     sb_clr_rn;
  logic [NU-1:0]     overflow_err;

  ex_commit #(.NUM_UNITS(NU), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .unit_valid(unit_valid), .unit_rd(unit_rd), .unit_data(unit_data),
    .unit_stall(unit_stall), .rf_stall(rf_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sb_clr(sb_clr), .sb_clr_rn(sb_clr_rn), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[NU][$];
  int            lg;
  logic          exp_we, exp_clr;
  logic [RW-1:0] exp_waddr, exp_rn;
  logic [DW-1:0] exp_wdata;
  logic [NU-1:0] exp_ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int ncommit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NU-1:0] st;
    for (int i = 0; i < NU; i++) st[i] = (mq[i].size() != 0);
    chk({tag, ".rf_we"},     64'(rf_we),        64'(exp_we));
    chk({tag, ".rf_waddr"},  64'(rf_waddr),     64'(exp_waddr));
    chk({tag, ".rf_wdata"},  rf_wdata,          exp_wdata);
    chk({tag, ".sb_clr"},    64'(sb_clr),       64'(exp_clr));
    chk({tag, ".sb_clr_rn"}, 64'(sb_clr_rn),    64'(exp_rn));
    chk({tag, ".stall"},     64'(unit_stall),   64'(st));
    chk({tag, ".ovf"},       64'(overflow_err), 64'(exp_ovf));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NU; i++) mq[i].delete();
    lg = NU - 1;
    exp_we = 0; exp_clr = 0; exp_waddr = '0; exp_rn = '0; exp_wdata = '0; exp_ovf = '0;
  endtask

  // One clock edge of the reference: commit the round-robin winner, then accept arrivals.
  task automatic model_edge();
    int   g;
    ent_t e;
    g = -1;
    if (!rf_stall)
      for (int k = 1; k <= NU; k++)
        if (g < 0 && mq[(lg + k) % NU].size() > 0) g = (lg + k) % NU;
    exp_we = 0;
    exp_clr = 0;
    if (g >= 0) begin
      e = mq[g].pop_front();
      lg = g;
      if (e.rd != 0) begin
        exp_we = 1; exp_clr = 1;
        exp_waddr = e.rd; exp_rn = e.rd; exp_wdata = e.d;
      end
    end
    for (int i = 0; i < NU; i++)
      if (unit_valid[i]) begin
        if (mq[i].size() < 2) begin
          e.rd = unit_rd[i*RW +: RW];
          e.d  = unit_data[i*DW +: DW];
          mq[i].push_back(e);
        end else exp_ovf[i] = 1'b1;
      end
  endtask

  task automatic step(input string tag, input logic [NU-1:0] v, input logic [NU*RW-1:0] rd,
                      input logic [NU*DW-1:0] d, input logic rs);
    unit_valid = v; unit_rd = rd; unit_data = d; rf_stall = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    unit_valid = '0; unit_rd = '0; unit_data = '0; rf_stall = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  function automatic logic [NU*RW-1:0] prd(input logic [RW-1:0] r0, r1, r2);
    return {r2, r1, r0};
  endfunction

  function automatic logic [NU*DW-1:0] pd(input logic [DW-1:0] d0, d1, d2);
    return {d2, d1, d0};
  endfunction

  initial begin
    logic [NU-1:0]    rv;
    logic [NU*RW-1:0] rr;
    logic [NU*DW-1:0] rdat;

    do_reset();

    // Single result: one-cycle stall, write one edge after capture.
    step("single_cap", 3'b001, prd(5, 0, 0), pd(64'h1234, 0, 0), 0);
    chk("single_stall_hi", 64'(unit_stall), 64'(3'b001));
    chk("single_we_lo", 64'(rf_we), 64'(0));
    idle("single_commit");
    chk("single_waddr", 64'(rf_waddr), 64'd5);
    chk("single_wdata", rf_wdata, 64'h1234);
    chk("single_stall_lo", 64'(unit_stall), 64'(0));
    idle("single_after");

    // Round-robin from reset, then wrap from unit 2 to unit 0.
    do_reset();
    step("rr_cap", 3'b111, prd(1, 2, 3), pd(64'hA1, 64'hA2, 64'hA3), 0);
    idle("rr_c1"); chk("rr_first", 64'(rf_waddr), 64'd1);
    idle("rr_c2"); chk("rr_second", 64'(rf_waddr), 64'd2);
    idle("rr_c3"); chk("rr_third", 64'(rf_waddr), 64'd3);
    step("rr_cap2", 3'b101, prd(4, 0, 6), pd(64'hB0, 0, 64'hB2), 0);
    idle("rr_w1"); chk("rr_wrap0", 64'(rf_waddr), 64'd4);
    idle("rr_w2"); chk("rr_wrap2", 64'(rf_waddr), 64'd6);
    idle("rr_w3");

    // Skid: two back-to-back results on unit 0 while unit 1 streams.
    do_reset();
    step("skid0", 3'b011, prd(7, 20, 0), pd(64'h70, 64'h200, 0), 0);
    step("skid1", 3'b011, prd(8, 21, 0), pd(64'h80, 64'h210, 0), 0);
    chk("skid_no_ovf0", 64'(overflow_err[0]), 64'd0);
    step("skid2", 3'b010, prd(0, 22, 0), pd(0, 64'h220, 0), 0);
    step("skid3", 3'b010, prd(0, 23, 0), pd(0, 64'h230, 0), 0);
    for (int i = 0; i < 5; i++) idle("skid_drain");

    // Overflow on unit 1 under rf_stall: only two results survive.
    do_reset();
    for (int i = 0; i < 3; i++)
      step("ovf_push", 3'b010, prd(0, RW'(10 + i), 0), pd(0, 64'(100 + i), 0), 1);
    chk("ovf_flag", 64'(overflow_err), 64'(3'b010));
    ncommit = 0;
    for (int i = 0; i < 4; i++) begin
      idle("ovf_drain");
      if (rf_we === 1'b1) ncommit++;
    end
    chk("ovf_commits", 64'(ncommit), 64'd2);

    // Zero register result is consumed silently.
    step("zero_cap", 3'b100, prd(0, 0, 0), pd(0, 0, 64'hFFFF), 0);
    idle("zero_pop");
    chk("zero_we", 64'(rf_we), 64'd0);
    chk("zero_stall", 64'(unit_stall[2]), 64'd0);

    // Reset with four buffered results discards them all.
    step("mid_fill0", 3'b111, prd(11, 12, 13), pd(1, 2, 3), 1);
    step("mid_fill1", 3'b001, prd(14, 0, 0), pd(4, 0, 0), 1);
    do_reset();
    for (int i = 0; i < 3; i++) idle("mid_after");

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      for (int i = 0; i < NU; i++) begin
        rv[i] = ($urandom_range(0, 9) < 4);
        rr[i*RW +: RW] = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom_range(1, 63));
        rdat[i*DW +: DW] = {$urandom(), $urandom()};
      end
      step("rand", rv, rr, rdat, ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 8; i++) idle("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_commit.md
Name: ex_commit

Overview:
- Commit-side receiver for the execute units.
- Accepts one-cycle result pulses (valid, rd, data) from each execute unit and buffers them per unit in a 2-entry skid FIFO.
- Drives each unit's stall input, arbitrates round-robin, and issues one register-file write per cycle.
- Sits between the execute units and the register file / scoreboard clear port.

Parameters:
- NUM_UNITS, 3, number of execute units feeding commit (unit 0 = integer ALU).
- DW, 64, result data width.
- RW, 6, register number width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- unit_valid  input  NUM_UNITS  per-unit result pulse, one cycle per result.
- unit_rd  input  NUM_UNITS*RW  per-unit destination register; unit i occupies bits [i*RW +: RW].
- unit_data  input  NUM_UNITS*DW  per-unit result; unit i occupies bits [i*DW +: DW].
- unit_stall  output  NUM_UNITS  per-unit stall back to the execute unit and dispatch.
- rf_stall  input  1  register file cannot accept a write this cycle.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  RW  write register number (registered).
- rf_wdata  output  DW  write data (registered).
- sb_clr  output  1  scoreboard clear pulse, same cycle as the commit (registered).
- sb_clr_rn  output  RW  register whose pending bit is cleared (registered).
- overflow_err  output  NUM_UNITS  sticky per-unit overflow flag.

Behaviour:
- Reset (async, rst_n low):
  - All FIFOs empty; occupancy 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, sb_clr=0, sb_clr_rn=0, overflow_err=0.
  - Round-robin pointer last_grant=NUM_UNITS-1, so unit 0 has first priority.
  - Reset mid-operation discards all buffered results. No write is issued after rst_n deasserts until new unit_valid arrives.
- Capture:
  - On each posedge where unit_valid[i]=1, push {unit_rd, unit_data} of unit i into FIFO i.
  - Results are never sampled when unit_valid=0.
- Stall:
  - unit_stall[i] = (occ[i] != 0), decoded from registered occupancy only (no combinational path from any input).
  - The 2nd FIFO entry absorbs the one result already in flight when stall rises. An execute unit enabled in the cycle before stall asserted still delivers its result one cycle later.
- Arbitration (combinational, each cycle):
  - Eligible set = units with occ != 0.
  - If rf_stall=0 and the set is non-empty, grant the first eligible unit scanning from last_grant+1 upward, wrapping mod NUM_UNITS.
  - On grant: pop that FIFO head, set last_grant=granted index.
  - If rf_stall=1: no grant, no pop, last_grant unchanged.
- Commit outputs (registered at the same edge as the pop):
  - Granted head with rd != 0: rf_we=1, rf_waddr=rd, rf_wdata=data, sb_clr=1, sb_clr_rn=rd.
  - Granted head with rd == 0 (hardwired zero register): popped and consumed, rf_we=0, sb_clr=0.
  - No grant: rf_we=0, sb_clr=0; rf_waddr, rf_wdata, sb_clr_rn hold their previous values.
- Latency: unit_valid seen at edge E (captured) -> rf_we high after edge E+1, given no contention and rf_stall=0.
- Simultaneous push and pop on the same FIFO in one edge: occupancy unchanged; the FIFO stays in order (FIFO order).
- Overflow:
  - unit_valid[i]=1 while occ[i]=2 and unit i is not popped that edge: the result is dropped and overflow_err[i] sets.
  - overflow_err[i] clears only on reset.
  - Push when occ=2 with a pop in the same edge is legal: no error, occupancy stays 2.
- Ordering:
  - Results from one unit commit in arrival order.
  - There is no ordering guarantee across units; the scoreboard prevents WAW conflicts.

Test Plan:
- Single result: unit 0 pulse rd=5, data=0x1234 at edge E, other units idle, rf_stall=0 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234, sb_clr_rn=5 after E+1. unit_stall[0] high exactly one cycle.
- Round-robin: units 0, 1, 2 pulse simultaneously with rd=1, 2, 3, after reset -> commits rd 1, 2, 3 on three consecutive cycles. Then units 0 and 2 pulse together -> order is 0 then 2 (last_grant=2 wraps to 0).
- Skid: unit 0 pulses two back-to-back cycles (rd=7, then rd=8) while unit 1 holds a continuous stream -> both rd=7 and rd=8 buffered, overflow_err[0]=0, both commit in order. unit_stall[0] high while occ>0.
- Overflow: rf_stall=1, unit 1 pulses three consecutive cycles -> occ[1]=2, overflow_err[1]=1, third result never committed. After rf_stall drops, exactly two commits occur.
- Zero register: unit 2 pulse rd=0, data=0xFFFF -> FIFO drained, unit_stall[2] falls, rf_we and sb_clr stay 0.
- Reset mid-operation: FIFOs holding 4 results, assert rst_n low for one cycle -> all unit_stall=0, rf_we=0, overflow_err=0, and no write is issued afterwards.
